clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
Front-panel controller for the digital clock. It turns three debounced push-button levels (mode, shift, add) into the mode level and single-cycle command pulses that sequence time_set and the alarm-set block. It provides edge detection, add-button auto-repeat, an idle timeout back to run mode, and a one-cycle load strobe when a set mode exits. It sits between the button debouncers and the time_set / alarm_set datapaths.

Parameters:
REPEAT_DELAY, 8_000_000, cycles add_btn must stay high after its rising edge before the first auto-repeat pulse (>=2)
REPEAT_PERIOD, 2_000_000, cycles between later auto-repeat pulses while add_btn stays high (>=2)
TIMEOUT, 250_000_000, idle cycles in a set mode before a forced return to RUN (>=4)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is asynchronous and active-high
mode_btn  input  1  debounced mode button level, synchronous to clk
shift_btn  input  1  debounced shift button level
add_btn  input  1  debounced add button level
mode  output  2  current mode: 00 RUN, 01 SET_TIME, 10 SET_ALARM
set_time_en  output  1  high while mode==SET_TIME
set_time_shift  output  1  1-cycle pulse, advance time_set field select
set_time_add  output  1  1-cycle pulse, increment selected time field
set_alarm_en  output  1  high while mode==SET_ALARM
set_alarm_shift  output  1  1-cycle pulse for the alarm block
set_alarm_add  output  1  1-cycle pulse for the alarm block
time_load  output  1  1-cycle pulse: commit set time into the running counter
alarm_load  output  1  1-cycle pulse: commit alarm value

Behaviour:
- Reset (async, rst=1): mode=RUN, all pulses 0, all enables 0, button history regs 0, repeat/timeout counters 0. No load pulse on reset, even mid-set.
- Input stage: each button is sampled into reg _q, then _q2. The rising event is _q & ~_q2. All outputs are registered. A button first sampled high at edge k gives its pulse during the cycle after edge k+1 (2-cycle latency).
- FSM (states encoded as mode):
  - RUN: mode event -> SET_TIME.
  - SET_TIME: mode event -> SET_ALARM. Timeout -> RUN.
  - SET_ALARM: mode event -> RUN. Timeout -> RUN.
  - Enables and mode update in the same cycle as the state register.
- Load strobes: leaving SET_TIME for any reason pulses time_load for 1 cycle, aligned with the first cycle of the new mode. Leaving SET_ALARM pulses alarm_load the same way.
- Shift: a shift event in SET_TIME gives a set_time_shift pulse. In SET_ALARM it gives a set_alarm_shift pulse. In RUN it is ignored.
- Add:
  - A rising event gives an immediate add pulse, routed like shift.
  - While add_q stays 1, a repeat counter counts from the event. The first repeat pulse comes REPEAT_DELAY cycles after the initial pulse. Each later pulse comes REPEAT_PERIOD cycles after the previous one.
  - Releasing the button clears the counter. The counter saturates and never wraps.
  - Ignored in RUN; the counter is held at 0 there.
- Timeout: the counter runs only in set states. It clears on any mode, shift or add event, on any auto-repeat pulse, and on state entry. Reaching TIMEOUT-1 counts as a timeout, which forces RUN and clears the counter.
- Priority in the same cycle:
  - Mode event beats shift/add: those pulses are dropped, and auto-repeat restarts only on a fresh add edge in the new mode.
  - Mode event beats timeout: the FSM takes the mode transition, and exactly one load pulse is issued.
- No two pulse outputs of the same group (time or alarm) are ever high with the other group's enable high.
- Counter widths: $clog2(max param + 1).

Test Plan:
(Sim parameters: REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT=32.)
- Reset: rst pulse mid SET_TIME -> outputs immediately 0, mode=00, time_load never asserted. After release, all outputs stay 0 with buttons idle.
- Mode cycling: three 3-cycle mode_btn presses -> mode 01, 10, 00.
  - Each change is 2 cycles after the press.
  - time_load fires 1 cycle on 01->10; alarm_load fires 1 cycle on 10->00.
- Add auto-repeat in SET_TIME: hold add_btn 30 cycles -> set_time_add pulses at relative cycles 0, 8, 12, 16, 20, 24, 28 (7 pulses). Release -> no further pulses. set_alarm_add stays 0.
- Shift routing: shift presses in RUN -> no pulses. In SET_ALARM -> one set_alarm_shift per press, no set_time_shift. A 1-cycle press still yields exactly one pulse.
- Timeout: enter SET_TIME, then idle 32 cycles -> mode=00 and time_load 1 cycle. An add press at idle cycle 20 delays the timeout to 32 cycles after that event.
- Simultaneous events:
  - mode and add rising in the same cycle in SET_TIME -> mode=10, no add pulse, time_load once.
  - mode event on the exact timeout cycle -> mode=10, not 00, one time_load.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Front-panel controller: turns debounced button levels into the mode level,
// routed shift/add pulses with add auto-repeat, idle timeout and load strobes.
module clock_mode_ctrl #(
    parameter int REPEAT_DELAY  = 8_000_000,
    parameter int REPEAT_PERIOD = 2_000_000,
    parameter int TIMEOUT       = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       shift_btn,
    input  logic       add_btn,
    output logic [1:0] mode,
    output logic       set_time_en,
    output logic       set_time_shift,
    output logic       set_time_add,
    output logic       set_alarm_en,
    output logic       set_alarm_shift,
    output logic       set_alarm_add,
    output logic       time_load,
    output logic       alarm_load
);

    localparam int MAX_RP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_P  = (MAX_RP > TIMEOUT) ? MAX_RP : TIMEOUT;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_SET_TIME  = 2'b01,
        ST_SET_ALARM = 2'b10
    } state_t;

    logic mode_btn_q, mode_btn_q2;
    logic shift_btn_q, shift_btn_q2;
    logic add_btn_q, add_btn_q2;

    state_t state_q, state_d;
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    logic rep_first_q, rep_first_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;

    logic set_time_en_q, set_time_en_d;
    logic set_alarm_en_q, set_alarm_en_d;
    logic set_time_shift_q, set_time_shift_d;
    logic set_time_add_q, set_time_add_d;
    logic set_alarm_shift_q, set_alarm_shift_d;
    logic set_alarm_add_q, set_alarm_add_d;
    logic time_load_q, time_load_d;
    logic alarm_load_q, alarm_load_d;

    logic mode_ev, shift_ev, add_ev;
    logic in_set, go, rep_fire, activity, timeout;
    logic [CW-1:0] rep_target;

    // Two-stage button history used for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_btn_q   <= 1'b0;
            mode_btn_q2  <= 1'b0;
            shift_btn_q  <= 1'b0;
            shift_btn_q2 <= 1'b0;
            add_btn_q    <= 1'b0;
            add_btn_q2   <= 1'b0;
        end else begin
            mode_btn_q   <= mode_btn;
            mode_btn_q2  <= mode_btn_q;
            shift_btn_q  <= shift_btn;
            shift_btn_q2 <= shift_btn_q;
            add_btn_q    <= add_btn;
            add_btn_q2   <= add_btn_q;
        end
    end

    // Next-state, counters and pulse routing; a mode event overrides everything else
    always_comb begin
        mode_ev  = mode_btn_q & ~mode_btn_q2;
        shift_ev = shift_btn_q & ~shift_btn_q2;
        add_ev   = add_btn_q & ~add_btn_q2;
        in_set   = (state_q != ST_RUN);
        go       = in_set & ~mode_ev;

        rep_target = rep_first_q ? PERIOD_C : DELAY_C;
        rep_fire   = go & add_btn_q & ~add_ev & (rep_cnt_q == rep_target);

        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        if (!in_set || mode_ev || !add_btn_q) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else if (add_ev) begin
            rep_cnt_d   = CNT_ONE;
            rep_first_d = 1'b0;
        end else if (rep_fire) begin
            rep_cnt_d   = CNT_ONE;
            rep_first_d = 1'b1;
        end else if (rep_cnt_q != '0 && rep_cnt_q != CNT_MAX) begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
        end

        activity = mode_ev | shift_ev | add_ev | rep_fire;
        timeout  = in_set & ~activity & (to_cnt_q == TO_LAST);

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mode_ev) state_d = ST_SET_TIME;
            end
            ST_SET_TIME: begin
                if (mode_ev) state_d = ST_SET_ALARM;
                else if (timeout) state_d = ST_RUN;
            end
            ST_SET_ALARM: begin
                if (mode_ev || timeout) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        to_cnt_d = to_cnt_q;
        if (!in_set || activity || timeout || state_d != state_q) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != CNT_MAX) begin
            to_cnt_d = to_cnt_q + CNT_ONE;
        end

        set_time_shift_d  = go & (state_q == ST_SET_TIME) & shift_ev;
        set_time_add_d    = go & (state_q == ST_SET_TIME) & (add_ev | rep_fire);
        set_alarm_shift_d = go & (state_q == ST_SET_ALARM) & shift_ev;
        set_alarm_add_d   = go & (state_q == ST_SET_ALARM) & (add_ev | rep_fire);

        time_load_d  = (state_q == ST_SET_TIME) & (state_d != ST_SET_TIME);
        alarm_load_d = (state_q == ST_SET_ALARM) & (state_d != ST_SET_ALARM);

        set_time_en_d  = (state_d == ST_SET_TIME);
        set_alarm_en_d = (state_d == ST_SET_ALARM);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_RUN;
            rep_cnt_q         <= '0;
            rep_first_q       <= 1'b0;
            to_cnt_q          <= '0;
            set_time_en_q     <= 1'b0;
            set_alarm_en_q    <= 1'b0;
            set_time_shift_q  <= 1'b0;
            set_time_add_q    <= 1'b0;
            set_alarm_shift_q <= 1'b0;
            set_alarm_add_q   <= 1'b0;
            time_load_q       <= 1'b0;
            alarm_load_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            rep_cnt_q         <= rep_cnt_d;
            rep_first_q       <= rep_first_d;
            to_cnt_q          <= to_cnt_d;
            set_time_en_q     <= set_time_en_d;
            set_alarm_en_q    <= set_alarm_en_d;
            set_time_shift_q  <= set_time_shift_d;
            set_time_add_q    <= set_time_add_d;
            set_alarm_shift_q <= set_alarm_shift_d;
            set_alarm_add_q   <= set_alarm_add_d;
            time_load_q       <= time_load_d;
            alarm_load_q      <= alarm_load_d;
        end
    end

    assign mode            = state_q;
    assign set_time_en     = set_time_en_q;
    assign set_alarm_en    = set_alarm_en_q;
    assign set_time_shift  = set_time_shift_q;
    assign set_time_add    = set_time_add_q;
    assign set_alarm_shift = set_alarm_shift_q;
    assign set_alarm_add   = set_alarm_add_q;
    assign time_load       = time_load_q;
    assign alarm_load      = alarm_load_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: a timestamp-based reference model
// queues the expected outputs per clock, a monitor pops and compares them.
module tb_clock_mode_ctrl;

    localparam int RD = 8;
    localparam int RP = 4;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode_btn = 1'b0;
    logic shift_btn = 1'b0;
    logic add_btn = 1'b0;
    logic [1:0] mode;
    logic set_time_en, set_time_shift, set_time_add;
    logic set_alarm_en, set_alarm_shift, set_alarm_add;
    logic time_load, alarm_load;

    int checks = 0;
    int passes = 0;

    int n_tl = 0, n_al = 0, n_tadd = 0, n_aadd = 0, n_tsh = 0, n_ash = 0;

    logic [9:0] exp_q[$];

    clock_mode_ctrl #(
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .TIMEOUT      (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode_btn       (mode_btn),
        .shift_btn      (shift_btn),
        .add_btn        (add_btn),
        .mode           (mode),
        .set_time_en    (set_time_en),
        .set_time_shift (set_time_shift),
        .set_time_add   (set_time_add),
        .set_alarm_en   (set_alarm_en),
        .set_alarm_shift(set_alarm_shift),
        .set_alarm_add  (set_alarm_add),
        .time_load      (time_load),
        .alarm_load     (alarm_load)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] dut_vec();
        return {mode, set_time_en, set_time_shift, set_time_add,
                set_alarm_en, set_alarm_shift, set_alarm_add,
                time_load, alarm_load};
    endfunction

    // Reference model: button history as levels, add repeat and timeout
    // expressed as elapsed-time rules measured from event timestamps.
    int  n = 0;
    int  m_mode = 0;
    bit  s1m = 0, s2m = 0, s1s = 0, s2s = 0, s1a = 0, s2a = 0;
    int  add_t0 = -1;
    int  last_act = 0;

    always @(posedge clk) begin : model
        bit mev, sev, aev, set, rep, act, tmo, tl, al, sp, ap;
        int d, nxt;
        if (rst) begin
            m_mode = 0;
            s1m = 0; s2m = 0; s1s = 0; s2s = 0; s1a = 0; s2a = 0;
            add_t0 = -1;
            last_act = n;
            exp_q.push_back(10'b0);
        end else begin
            n = n + 1;
            mev = s1m && !s2m;
            sev = s1s && !s2s;
            aev = s1a && !s2a;
            set = (m_mode != 0);
            rep = 0;
            if (set && !mev && s1a && !aev && add_t0 >= 0) begin
                d = n - add_t0;
                rep = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
            end
            sp  = set && !mev && sev;
            ap  = set && !mev && (aev || rep);
            act = mev || sev || aev || rep;
            tmo = set && !act && ((n - last_act) == TO);
            nxt = mev ? (m_mode + 1) % 3 : (tmo ? 0 : m_mode);
            tl  = (m_mode == 1) && (nxt != 1);
            al  = (m_mode == 2) && (nxt != 2);
            exp_q.push_back({2'(nxt), nxt == 1, sp && m_mode == 1, ap && m_mode == 1,
                             nxt == 2, sp && m_mode == 2, ap && m_mode == 2, tl, al});
            if (!set || mev || !s1a) add_t0 = -1;
            else if (aev) add_t0 = n;
            if (act || nxt != m_mode) last_act = n;
            m_mode = nxt;
            s2m = s1m; s1m = mode_btn;
            s2s = s1s; s1s = shift_btn;
            s2a = s1a; s1a = add_btn;
        end
    end

    // Monitor: one expected vector per clock, compared away from the active edge
    always @(negedge clk) begin : monitor
        logic [9:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard underflow at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (dut_vec() === e) passes++;
            else $display("FAIL outputs at %0t: got %b expected %b", $time, dut_vec(), e);
        end
        if (time_load) n_tl++;
        if (alarm_load) n_al++;
        if (set_time_add) n_tadd++;
        if (set_alarm_add) n_aadd++;
        if (set_time_shift) n_tsh++;
        if (set_alarm_shift) n_ash++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic press_mode(input int len);
        mode_btn = 1'b1;
        idle(len);
        mode_btn = 1'b0;
    endtask

    task automatic press_shift(input int len);
        shift_btn = 1'b1;
        idle(len);
        shift_btn = 1'b0;
    endtask

    int b_tl, b_al, b_tadd, b_aadd, b_tsh, b_ash;

    task automatic snap();
        b_tl = n_tl; b_al = n_al; b_tadd = n_tadd;
        b_aadd = n_aadd; b_tsh = n_tsh; b_ash = n_ash;
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(5);
        check("idle_after_reset", int'(dut_vec()), 0);

        // Mode cycling
        snap();
        press_mode(3); idle(6);
        check("mode_set_time", mode, 1);
        press_mode(3); idle(6);
        check("mode_set_alarm", mode, 2);
        check("time_load_on_exit", n_tl - b_tl, 1);
        press_mode(3); idle(6);
        check("mode_run", mode, 0);
        check("alarm_load_on_exit", n_al - b_al, 1);

        // Reset in the middle of SET_TIME
        press_mode(3); idle(4);
        snap();
        rst = 1'b1;
        #1;
        check("async_reset_outputs", int'(dut_vec()), 0);
        idle(2);
        rst = 1'b0;
        idle(10);
        check("no_load_on_reset", n_tl - b_tl, 0);
        check("mode_after_reset", mode, 0);

        // Add auto-repeat in SET_TIME, then idle timeout
        press_mode(3); idle(4);
        snap();
        add_btn = 1'b1;
        idle(30);
        add_btn = 1'b0;
        idle(10);
        check("auto_repeat_pulses", n_tadd - b_tadd, 7);
        check("no_alarm_add", n_aadd - b_aadd, 0);
        idle(40);
        check("timeout_mode", mode, 0);
        check("timeout_time_load", n_tl - b_tl, 1);

        // Shift routing
        snap();
        press_shift(1); idle(3);
        press_shift(3); idle(3);
        check("run_shift_ignored", (n_tsh - b_tsh) + (n_ash - b_ash), 0);
        press_mode(3); idle(5);
        press_mode(3); idle(5);
        snap();
        press_shift(1); idle(3);
        press_shift(3); idle(3);
        check("alarm_shift_pulses", n_ash - b_ash, 2);
        check("no_time_shift", n_tsh - b_tsh, 0);
        press_mode(3); idle(5);

        // Add press delays the timeout
        snap();
        press_mode(1); idle(20);
        add_btn = 1'b1; idle(1); add_btn = 1'b0;
        idle(25);
        check("timeout_delayed", mode, 1);
        idle(15);
        check("timeout_after_add", mode, 0);
        check("timeout_add_load", n_tl - b_tl, 1);

        // Mode and add rising together
        press_mode(3); idle(4);
        snap();
        mode_btn = 1'b1; add_btn = 1'b1;
        idle(2);
        mode_btn = 1'b0; add_btn = 1'b0;
        idle(4);
        check("simul_mode", mode, 2);
        check("simul_no_time_add", n_tadd - b_tadd, 0);
        check("simul_no_alarm_add", n_aadd - b_aadd, 0);
        check("simul_time_load", n_tl - b_tl, 1);
        press_mode(3); idle(5);

        // Mode event lands on the exact timeout cycle
        snap();
        press_mode(1);
        idle(31);
        press_mode(1);
        idle(4);
        check("timeout_tie_mode", mode, 2);
        check("timeout_tie_load", n_tl - b_tl, 1);
        press_mode(3); idle(5);

        // Randomized button activity
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 29) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 5) == 0) shift_btn = ~shift_btn;
            if ($urandom_range(0, 7) == 0) add_btn = ~add_btn;
            if (i % 200 == 199) begin
                mode_btn = 1'b0; shift_btn = 1'b0; add_btn = 1'b0;
                idle(40);
            end
            tick();
        end
        mode_btn = 1'b0; shift_btn = 1'b0; add_btn = 1'b0;
        idle(50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
